// File: rtl/actuator_tcdm_arbiter_pkg.sv
// Shared types and constants for the actuator TCDM arbiter and its ID FIFO.
package actuator_tcdm_arbiter_pkg;

  localparam int unsigned ACT_NB_TCDM_REQ  = 4;

  localparam int unsigned ACT_STREAM_IN_R  = 0;
  localparam int unsigned ACT_STREAM_IN_I  = 1;
  localparam int unsigned ACT_STREAM_OUT_R = 2;
  localparam int unsigned ACT_STREAM_OUT_I = 3;

  localparam int unsigned ACT_TCDM_AW = 32;
  localparam int unsigned ACT_TCDM_DW = 32;
  localparam int unsigned ACT_TCDM_BW = ACT_TCDM_DW / 8;

  typedef struct packed {
    logic [ACT_TCDM_AW-1:0] add;
    logic                   wen;
    logic [ACT_TCDM_BW-1:0] be;
    logic [ACT_TCDM_DW-1:0] data;
  } tcdm_req_t;

endpackage

// File: rtl/actuator_id_fifo.sv
// In-order FIFO of requester indices, one entry per outstanding TCDM transaction.
module actuator_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/actuator_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among the actuator streams;
// responses are routed back in order through an ID FIFO.
module actuator_tcdm_arbiter
  import actuator_tcdm_arbiter_pkg::*;
#(
  parameter int unsigned NB_REQ    = ACT_NB_TCDM_REQ,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned AW        = ACT_TCDM_AW,
  parameter int unsigned DW        = ACT_TCDM_DW
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic [NB_REQ-1:0]             req_i,
  output logic [NB_REQ-1:0]             gnt_o,
  input  logic [NB_REQ-1:0][AW-1:0]     add_i,
  input  logic [NB_REQ-1:0]             wen_i,
  input  logic [NB_REQ-1:0][DW/8-1:0]   be_i,
  input  logic [NB_REQ-1:0][DW-1:0]     data_i,
  output logic [DW-1:0]                 r_data_o,
  output logic [NB_REQ-1:0]             r_valid_o,
  output logic                          tcdm_req_o,
  input  logic                          tcdm_gnt_i,
  output logic [AW-1:0]                 tcdm_add_o,
  output logic                          tcdm_wen_o,
  output logic [DW/8-1:0]               tcdm_be_o,
  output logic [DW-1:0]                 tcdm_data_o,
  input  logic [DW-1:0]                 tcdm_r_data_i,
  input  logic                          tcdm_r_valid_i,
  output logic                          busy_o,
  output logic [$clog2(MAX_OUTST):0]    outst_o,
  output logic                          err_o
);

  localparam int unsigned IW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTST) + 1;

  logic            rst_any;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_idx, sel_idx, cand_idx;
  logic            win_vld;
  int unsigned     cand;
  logic            req_c, hs_c, pop_c;
  logic            fifo_full, fifo_empty;
  logic [IW-1:0]   fifo_head;
  logic [CW-1:0]   fifo_cnt;
  logic            err_q;
  tcdm_req_t       req_arr [NB_REQ];
  tcdm_req_t       win_req;

  assign rst_any = rst_i | clear_i;

  always_comb begin
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      req_arr[i].add  = ACT_TCDM_AW'(add_i[i]);
      req_arr[i].wen  = wen_i[i];
      req_arr[i].be   = ACT_TCDM_BW'(be_i[i]);
      req_arr[i].data = ACT_TCDM_DW'(data_i[i]);
    end
  end

  // First requester at or after the pointer, wrapping at NB_REQ.
  always_comb begin
    win_idx  = '0;
    win_vld  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < NB_REQ; off++) begin
      cand = 32'(ptr_q) + off;
      if (cand >= NB_REQ) cand = cand - NB_REQ;
      cand_idx = IW'(cand);
      if (!win_vld && req_i[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  assign req_c   = (|req_i) & ~fifo_full;
  assign hs_c    = req_c & tcdm_gnt_i;
  assign sel_idx = win_vld ? win_idx : '0;
  assign win_req = req_arr[sel_idx];
  assign ptr_d   = (win_idx == IW'(NB_REQ - 1)) ? '0 : win_idx + IW'(1);

  assign tcdm_req_o  = req_c;
  assign tcdm_add_o  = AW'(win_req.add);
  assign tcdm_wen_o  = win_req.wen;
  assign tcdm_be_o   = (DW/8)'(win_req.be);
  assign tcdm_data_o = DW'(win_req.data);

  always_comb begin
    gnt_o = '0;
    if (hs_c && win_vld) gnt_o[win_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_any)   ptr_q <= '0;
    else if (hs_c) ptr_q <= ptr_d;
  end

  actuator_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IW)
  ) i_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_any),
    .push  (hs_c),
    .pop   (pop_c),
    .data  (win_idx),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Response routing to the oldest outstanding requester.
  assign pop_c    = tcdm_r_valid_i & ~fifo_empty;
  assign r_data_o = tcdm_r_data_i;

  always_comb begin
    r_valid_o = '0;
    if (pop_c) r_valid_o[fifo_head] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_any)                           err_q <= 1'b0;
    else if (tcdm_r_valid_i && fifo_empty) err_q <= 1'b1;
  end

  assign err_o   = err_q;
  assign outst_o = fifo_cnt;
  assign busy_o  = (fifo_cnt != '0);

endmodule

// File: tb/tb_actuator_tcdm_arbiter.sv
// Scoreboard bench for actuator_tcdm_arbiter: directed stimulus pushes expected
// grants/responses, a negedge monitor pops and compares them.
module tb_actuator_tcdm_arbiter;

  localparam int unsigned NB = 4;

  typedef struct packed {
    logic [3:0]  rv;
    logic [31:0] data;
  } resp_t;

  logic             clk_i = 1'b0;
  logic             rst_i, clear_i;
  logic [3:0]       req_i, gnt_o, wen_i, r_valid_o;
  logic [3:0][31:0] add_i, data_i;
  logic [3:0][3:0]  be_i;
  logic [31:0]      r_data_o, tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
  logic             tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic [3:0]       tcdm_be_o;
  logic             busy_o, err_o;
  logic [2:0]       outst_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_gnt[$];
  resp_t      exp_resp[$];

  always #5 clk_i = ~clk_i;

  actuator_tcdm_arbiter #(.NB_REQ(4), .MAX_OUTST(4), .AW(32), .DW(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .wen_i(wen_i),
    .be_i(be_i), .data_i(data_i), .r_data_o(r_data_o), .r_valid_o(r_valid_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .busy_o(busy_o), .outst_o(outst_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
    step();
    req_i          = req;
    tcdm_gnt_i     = gnt;
    tcdm_r_valid_i = rv;
    tcdm_r_data_i  = rdata;
  endtask

  task automatic do_clear();
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  // Monitor: compares DUT grants and routed responses against the scoreboard.
  always @(negedge clk_i) begin
    if (gnt_o != 4'b0 || exp_gnt.size() != 0) begin
      if (exp_gnt.size() == 0) chk("unexpected_grant", 64'(gnt_o), 64'(0));
      else chk("grant", 64'(gnt_o), 64'(exp_gnt.pop_front()));
    end
    if (tcdm_r_valid_i || exp_resp.size() != 0) begin
      if (exp_resp.size() == 0) begin
        chk("unexpected_response", 64'(r_valid_o), 64'(0));
      end else begin
        resp_t e;
        e = exp_resp.pop_front();
        chk("r_valid", 64'(r_valid_o), 64'(e.rv));
        chk("r_data", 64'(r_data_o), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; req_i = '0; tcdm_gnt_i = 1'b0;
    tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0;
    for (int k = 0; k < 4; k++) begin
      add_i[k]  = 32'h1000 * 32'(k + 1);
      data_i[k] = 32'hA0 + 32'(k);
      be_i[k]   = 4'hF;
    end
    wen_i = 4'b1011;
    be_i[2] = 4'h3;

    // Reset state
    step(); step();
    @(negedge clk_i);
    chk("rst_gnt", 64'(gnt_o), 64'(0));
    chk("rst_rvalid", 64'(r_valid_o), 64'(0));
    chk("rst_tcdm_req", 64'(tcdm_req_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_outst", 64'(outst_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    step();
    rst_i = 1'b0;

    // Single read
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    exp_gnt.push_back(4'b0001);
    @(negedge clk_i);
    chk("single_add", 64'(tcdm_add_o), 64'(32'h1000));
    chk("single_wen", 64'(tcdm_wen_o), 64'(1));
    drive(4'b0000, 1'b0, 1'b1, 32'hCAFE);
    exp_resp.push_back('{4'b0001, 32'hCAFE});
    @(negedge clk_i);
    chk("single_outst1", 64'(outst_o), 64'(1));
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    chk("single_outst0", 64'(outst_o), 64'(0));
    chk("single_busy0", 64'(busy_o), 64'(0));

    // Fairness with 1-cycle responses
    do_clear();
    for (int k = 0; k <= 6; k++) begin
      drive((k < 6) ? 4'b1111 : 4'b0000, k < 6, k > 0, 32'h100 + 32'(k));
      if (k < 6) exp_gnt.push_back(4'b0001 << (k % 4));
      if (k > 0) exp_resp.push_back('{4'b0001 << ((k - 1) % 4), 32'h100 + 32'(k)});
    end
    drive(4'b0000, 1'b0, 1'b0, 32'h0);

    // Stall hold: pointer moved to 1, then requester 1 stalled
    do_clear();
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    exp_gnt.push_back(4'b0001);
    drive(4'b0000, 1'b0, 1'b1, 32'h11);
    exp_resp.push_back('{4'b0001, 32'h11});
    for (int k = 0; k < 5; k++) begin
      drive(4'b0110, 1'b0, 1'b0, 32'h0);
      @(negedge clk_i);
      chk("stall_add", 64'(tcdm_add_o), 64'(32'h2000));
    end
    chk("stall_req", 64'(tcdm_req_o), 64'(1));
    drive(4'b0110, 1'b1, 1'b0, 32'h0);
    exp_gnt.push_back(4'b0010);
    drive(4'b0100, 1'b1, 1'b0, 32'h0);
    exp_gnt.push_back(4'b0100);
    drive(4'b0000, 1'b0, 1'b1, 32'h21);
    exp_resp.push_back('{4'b0010, 32'h21});
    drive(4'b0000, 1'b0, 1'b1, 32'h22);
    exp_resp.push_back('{4'b0100, 32'h22});
    drive(4'b0000, 1'b0, 1'b0, 32'h0);

    // Full back-pressure
    do_clear();
    for (int k = 0; k < 4; k++) begin
      drive(4'b1111, 1'b1, 1'b0, 32'h0);
      exp_gnt.push_back(4'b0001 << k);
    end
    drive(4'b1111, 1'b1, 1'b0, 32'h0);
    @(negedge clk_i);
    chk("full_req", 64'(tcdm_req_o), 64'(0));
    chk("full_outst", 64'(outst_o), 64'(4));
    drive(4'b1111, 1'b1, 1'b1, 32'h31);
    exp_resp.push_back('{4'b0001, 32'h31});
    @(negedge clk_i);
    chk("full_pop_req", 64'(tcdm_req_o), 64'(0));
    drive(4'b1111, 1'b1, 1'b0, 32'h0);
    exp_gnt.push_back(4'b0001);
    @(negedge clk_i);
    chk("full_reenable", 64'(tcdm_req_o), 64'(1));
    drive(4'b0000, 1'b0, 1'b1, 32'h32);
    exp_resp.push_back('{4'b0010, 32'h32});
    drive(4'b0000, 1'b0, 1'b1, 32'h33);
    exp_resp.push_back('{4'b0100, 32'h33});
    drive(4'b0000, 1'b0, 1'b1, 32'h34);
    exp_resp.push_back('{4'b1000, 32'h34});
    drive(4'b0000, 1'b0, 1'b1, 32'h35);
    exp_resp.push_back('{4'b0001, 32'h35});
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    chk("full_drained", 64'(outst_o), 64'(0));

    // Out-of-requester-order routing: grants 2, 0, 3
    do_clear();
    drive(4'b0100, 1'b1, 1'b0, 32'h0);
    exp_gnt.push_back(4'b0100);
    @(negedge clk_i);
    chk("ooo_wen", 64'(tcdm_wen_o), 64'(0));
    chk("ooo_data", 64'(tcdm_data_o), 64'(32'hA2));
    chk("ooo_be", 64'(tcdm_be_o), 64'(4'h3));
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    exp_gnt.push_back(4'b0001);
    drive(4'b1000, 1'b1, 1'b0, 32'h0);
    exp_gnt.push_back(4'b1000);
    drive(4'b0000, 1'b0, 1'b1, 32'h41);
    exp_resp.push_back('{4'b0100, 32'h41});
    drive(4'b0000, 1'b0, 1'b1, 32'h42);
    exp_resp.push_back('{4'b0001, 32'h42});
    drive(4'b0000, 1'b0, 1'b1, 32'h43);
    exp_resp.push_back('{4'b1000, 32'h43});
    drive(4'b0000, 1'b0, 1'b0, 32'h0);

    // Error on empty FIFO, then clear
    drive(4'b0000, 1'b0, 1'b1, 32'h55);
    exp_resp.push_back('{4'b0000, 32'h55});
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    chk("err_set", 64'(err_o), 64'(1));
    chk("err_outst", 64'(outst_o), 64'(0));
    step();
    @(negedge clk_i);
    chk("err_sticky", 64'(err_o), 64'(1));
    do_clear();
    @(negedge clk_i);
    chk("clr_err", 64'(err_o), 64'(0));
    chk("clr_outst", 64'(outst_o), 64'(0));
    drive(4'b1111, 1'b1, 1'b0, 32'h0);
    exp_gnt.push_back(4'b0001);
    drive(4'b0000, 1'b0, 1'b1, 32'h66);
    exp_resp.push_back('{4'b0001, 32'h66});
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    step();
    @(negedge clk_i);
    chk("end_gnt_queue", 64'(exp_gnt.size()), 64'(0));
    chk("end_resp_queue", 64'(exp_resp.size()), 64'(0));
    chk("end_busy", 64'(busy_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/actuator_tcdm_arbiter.md
Name: actuator_tcdm_arbiter

Overview:
Round-robin arbiter that shares one TCDM master port among the four actuator stream channels: in_r, in_i, out_r and out_i. It sits between the streamer's per-stream TCDM request ports and the cluster TCDM interconnect. An in-order ID FIFO routes each response back to the requester that issued it. The block lets the actuator run on a single memory port without changing the control FSM.

Parameters:
NB_REQ, 4, number of requester channels; index 0..3 = in_r, in_i, out_r, out_i.
MAX_OUTST, 4, maximum outstanding transactions; power of two, at least 2.
AW, 32, address width.
DW, 32, data width; byte-enable width is DW/8.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
clear_i  in  1  synchronous soft clear; same effect as rst_i
req_i  in  NB_REQ  per-requester request
gnt_o  out  NB_REQ  per-requester grant
add_i  in  NB_REQ x AW  per-requester address
wen_i  in  NB_REQ  per-requester write-enable, active-low (1 = read)
be_i  in  NB_REQ x DW/8  per-requester byte enables
data_i  in  NB_REQ x DW  per-requester write data
r_data_o  out  DW  response data, broadcast to all requesters
r_valid_o  out  NB_REQ  per-requester response valid, one-hot or zero
tcdm_req_o  out  1  master request
tcdm_gnt_i  in  1  master grant
tcdm_add_o  out  AW  master address
tcdm_wen_o  out  1  master write-enable, active-low
tcdm_be_o  out  DW/8  master byte enables
tcdm_data_o  out  DW  master write data
tcdm_r_data_i  in  DW  master response data
tcdm_r_valid_i  in  1  master response valid
busy_o  out  1  at least one transaction outstanding
outst_o  out  $clog2(MAX_OUTST)+1  outstanding transaction count
err_o  out  1  sticky: response received with no transaction outstanding

Behaviour:
- Reset and clear: when rst_i or clear_i is high at a clock edge:
  - Priority pointer goes to 0, the FIFO empties, outst_o = 0 and err_o = 0.
  - Combinational outputs then follow: gnt_o = 0, r_valid_o = 0, tcdm_req_o = 0 while no requester is asserting req_i, busy_o = 0.
- Arbitration (combinational, zero latency):
  - Search req_i starting at the pointer index and wrapping modulo NB_REQ; the first set bit is the winner.
  - tcdm_req_o = |req_i & !fifo_full.
  - The tcdm_add/wen/be/data outputs mux the winner's inputs. When there is no winner, they drive the index-0 inputs.
- Grant: gnt_o[winner] = tcdm_gnt_i & tcdm_req_o. All other gnt_o bits are 0.
- Handshake: tcdm_req_o & tcdm_gnt_i. Reads and writes are treated the same.
  - On handshake, the winner index is pushed into the ID FIFO and the pointer becomes (winner+1) mod NB_REQ.
  - With no handshake, the pointer holds. A requester is never skipped while it is stalled by tcdm_gnt_i = 0.
- Request stability: a requester holds req/add/wen/be/data until granted. The arbiter may switch winner between cycles only if the current winner drops req, which is a protocol violation and is not checked.
- Response: every handshake produces exactly one tcdm_r_valid_i, in order, at least 1 cycle later.
  - On tcdm_r_valid_i with the FIFO not empty, r_valid_o[fifo_head] = 1 in the same cycle (combinational) and the head pops.
  - r_data_o = tcdm_r_data_i at all times.
- Empty-FIFO response: tcdm_r_valid_i with the FIFO empty sets err_o, pops nothing and keeps r_valid_o = 0.
- Full FIFO: when outst_o = MAX_OUTST, tcdm_req_o is forced to 0 and no grants are issued. A response arriving in a full cycle pops; tcdm_req_o re-enables the following cycle (registered full flag).
- Simultaneous push and pop: outst_o is unchanged and the FIFO order is preserved.
- busy_o = (outst_o != 0).
- Pointer arithmetic: $clog2(NB_REQ) bits. Wrap from NB_REQ-1 to 0 is explicit, so non-power-of-two NB_REQ is legal.
- Reset mid-operation: in-flight responses arriving after rst_i or clear_i hit an empty FIFO and set err_o. Software must drain the block (busy_o = 0) before clearing.

Decomposition:
- actuator_package gains:
  - ACT_NB_TCDM_REQ = 4.
  - Stream index constants ACT_STREAM_IN_R = 0, ACT_STREAM_IN_I = 1, ACT_STREAM_OUT_R = 2, ACT_STREAM_OUT_I = 3.
  - A tcdm_req_t struct (add, wen, be, data) used for the per-requester arrays.
- Sub-module actuator_id_fifo: a synchronous FIFO of depth MAX_OUTST and width $clog2(NB_REQ).
  - Ports: push, pop, data in, head out, full, empty, count; synchronous active-high reset.
  - Same-cycle push and pop is legal when the FIFO is neither empty nor full.

Test Plan:
- Single read: req_i = 0001, add 0x1000, tcdm_gnt_i = 1 -> gnt_o = 0001 in the same cycle, outst_o = 1; r_valid next cycle with data 0xCAFE -> r_valid_o = 0001, r_data_o = 0xCAFE, outst_o = 0.
- Fairness: req_i = 1111 held, gnt always 1, 1-cycle response -> grant sequence 0, 1, 2, 3, 0, 1, each requester granted exactly once every 4 handshakes.
- Stall hold: req_i = 0110, pointer = 1, tcdm_gnt_i = 0 for 5 cycles, then 1 -> requester 1 granted; pointer becomes 2; requester 2 granted next cycle.
- Full back-pressure: MAX_OUTST = 4, 4 grants with no responses -> tcdm_req_o = 0 with req_i = 1111; one response -> requester of the oldest transaction gets r_valid; tcdm_req_o = 1 the next cycle.
- Out-of-requester order routing: grant order 2, 0, 3, then three responses -> r_valid_o = 0100, 0001, 1000 in that order.
- Error and clear: tcdm_r_valid_i with the FIFO empty -> err_o = 1 sticky; clear_i pulse -> err_o = 0, outst_o = 0, pointer = 0 (req_i = 1111 grants index 0 next).
